// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: one write per rising edge of
// rx_done, first-word-fall-through read, sticky overflow when a byte is dropped.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_done,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rd,
    input  logic                  clr_ovf,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  rx_done_q, rx_done_d;

    logic wr_s;
    logic wr_acc_s;
    logic rd_acc_s;
    logic drop_s;
    logic empty_s;
    logic full_s;

    // Status is derived only from the occupancy counter, never from pointer equality.
    always_comb begin
        empty_s  = (count_q == {(ADDR_WIDTH + 1){1'b0}});
        full_s   = (count_q == DEPTH_C);
        wr_s     = rx_done & ~rx_done_q;
        wr_acc_s = wr_s & (~full_s | rd);
        drop_s   = wr_s & full_s & ~rd;
        rd_acc_s = rd & ~empty_s;
    end

    // Next-state for pointers, occupancy, edge detector and sticky overflow.
    always_comb begin
        rx_done_d  = rx_done;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // A dropped byte takes priority over a same-cycle clear.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers; rx_done_q resets high so a flag already up at release is not a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q   <= {ADDR_WIDTH{1'b0}};
            count_q    <= {(ADDR_WIDTH + 1){1'b0}};
            overflow_q <= 1'b0;
            rx_done_q  <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rx_done_q  <= rx_done_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Output drive; rd_data falls through from the registered read pointer.
    always_comb begin
        rd_data  = mem_q[rd_ptr_q];
        empty    = empty_s;
        full     = full_s;
        count    = count_q;
        overflow = overflow_q;
    end

endmodule
